softmax_vector_collector: RTL and testbench
===========================================

// Module: softmax_vector_collector
// PURPOSE
//  Writer side of the softmax_out array consumed by comparingSoftmax.
//  Accepts per-class IEEE-754 single exp values serially (valid/ready).
//  Packs them into a double-buffered NUM_CLASSES-entry vector.
//  Presents the full vector as one flat bus with out_valid/out_ack, so the
//  next vector can fill while the comparator reads the current one.
// PARAMETERS
//  datawidth    32  width of one float element (IEEE-754 single)
//  NUM_CLASSES  10  elements per vector (the comparator needs 10)
//  CNTW          4  element-index counter width (2**CNTW >= NUM_CLASSES)
// PORTS
//  clock        in   1                     system clock, rising edge
//  reset        in   1                     asynchronous, active-high
//  in_valid     in   1                     in_data/in_last valid this cycle
//  in_ready     out  1                     collector can accept a word
//  in_data      in   datawidth             exp value for current class
//  in_last      in   1                     marks element NUM_CLASSES-1
//  out_valid    out  1                     full vector on softmax_flat
//  out_ack      in   1                     consumer has taken vector
//  softmax_flat out  NUM_CLASSES*datawidth element i = [i*datawidth +: datawidth]
//  out_bad      out  1                     presented vector has >=1 bad element
//  frame_err    out  1                     1-cycle pulse: in_last misaligned
//  vec_count    out  8                     vectors delivered (acked), wraps 255->0
// BEHAVIOUR
//  Reset values:
//   - banks, counters, out_valid, out_bad, frame_err, vec_count = 0
//   - wbank = rbank = 0; both banks EMPTY
//  Per-bank state: EMPTY -> FULL (last word accepted) -> EMPTY (acked).
//  Transfer: word accepted iff in_valid && in_ready at a rising clock edge.
//   - in_ready = !FULL[wbank], combinational from registered state.
//   - in_ready = 1 out of reset.
//  Write:
//   - accepted word stored at bank[wbank][idx]; idx increments.
//   - idx == NUM_CLASSES-1 with in_last=1: bank FULL, idx -> 0, wbank toggles.
//  Frame error (frame_err pulses 1 cycle; partial vector discarded):
//   - in_last=1 at idx < NUM_CLASSES-1, or in_last=0 at idx == NUM_CLASSES-1.
//   - idx -> 0; bank stays EMPTY; wbank unchanged.
//  Bad element: sign bit 1, or exponent field all ones (Inf/NaN).
//   - sets the sticky bad flag of the bank being written.
//   - flag cleared when that bank starts a new vector (idx 0 write).
//  Read:
//   - out_valid = FULL[rbank], registered.
//   - softmax_flat and out_bad driven from bank[rbank].
//   - both held stable while out_valid && !out_ack.
//  Latency: out_valid rises the cycle after the last word is accepted
//   (if rbank was EMPTY).
//  Ack:
//   - out_valid && out_ack: bank[rbank] -> EMPTY, rbank toggles, vec_count++.
//   - out_ack with out_valid=0 is ignored.
//  Simultaneous: last-word write to one bank and ack of the other in the same
//   cycle both take effect; throughput is 1 word/cycle sustained.
//  Both FULL: in_ready = 0. It returns to 1 the cycle after an ack.
//  Reset mid-vector: asynchronously discards all banks; no out_valid follows.
// TESTING
//  1. 10 words, in_last on 10th: 402D70A4, 3F800000, 3F1B4396, 3FD3089A,
//     3F519653, 3F519653, 3FBEF34D, 3EBC5048, 4000E076, 401D6A16.
//     -> out_valid next cycle; element0 = 402D70A4; element9 = 401D6A16;
//        out_bad = 0.
//  2. Three back-to-back vectors, out_ack held 0.
//     -> in_ready drops after the 20th word; third vector stalls.
//     -> ack: vector 1 out, then vector 2; in_ready returns; vec_count = 1.
//  3. in_last on 7th word -> frame_err pulse; no out_valid.
//     -> next clean 10-word vector is delivered correctly.
//  4. Element 4 = BF800000 (negative) or 7FC00000 (NaN) -> out_bad = 1 for
//     that vector only; following clean vector out_bad = 0.
//  5. Ack of bank0 on the same cycle as the last word of bank1.
//     -> out_valid stays 1; softmax_flat switches to bank1.
//  6. Reset asserted mid-vector (after word 5) -> all outputs 0.
//     -> in_ready = 1; 256 acked vectors: vec_count wraps to 0.

Source files
------------

// File: rtl/softmax_vector_collector_if.sv
// rtl/softmax_vector_collector_if.sv - word input stream and flat vector output bus of the softmax collector
interface softmax_vector_collector_if #(
   parameter int datawidth   = 32,
   parameter int NUM_CLASSES = 10
);
   logic                             in_valid;
   logic                             in_ready;
   logic [datawidth-1:0]             in_data;
   logic                             in_last;
   logic                             out_valid;
   logic                             out_ack;
   logic [NUM_CLASSES*datawidth-1:0] softmax_flat;
   logic                             out_bad;
   logic                             frame_err;
   logic [7:0]                       vec_count;

   modport master (
      output in_valid, in_data, in_last, out_ack,
      input  in_ready, out_valid, softmax_flat, out_bad, frame_err, vec_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ack,
      output in_ready, out_valid, softmax_flat, out_bad, frame_err, vec_count
   );
endinterface

// File: rtl/softmax_vector_collector.sv
// rtl/softmax_vector_collector.sv - double-buffered collector packing serial exp words into a flat softmax vector
module softmax_vector_collector #(
   parameter int datawidth   = 32,
   parameter int NUM_CLASSES = 10,
   parameter int CNTW        = 4
) (
   input logic                    clock,
   input logic                    reset,
   softmax_vector_collector_if.slave bus
);
   typedef enum logic {BANK_EMPTY = 1'b0, BANK_FULL = 1'b1} bank_state_t;

   bank_state_t                 state_q [2];
   bank_state_t                 state_d [2];
   logic                        wbank;
   logic                        rbank;
   logic [CNTW-1:0]             idx;
   logic [1:0]                  bad;
   logic                        frame_err_q;
   logic [7:0]                  vec_count_q;
   logic [datawidth-1:0]        mem [2][NUM_CLASSES];
   logic [NUM_CLASSES*datawidth-1:0] flat;

   logic accept;
   logic at_end;
   logic completes;
   logic misframed;
   logic ack;
   logic elem_bad;

   assign bus.in_ready  = (state_q[wbank] == BANK_EMPTY);
   assign bus.out_valid = (state_q[rbank] == BANK_FULL);

   assign accept    = bus.in_valid && bus.in_ready;
   assign at_end    = (idx == CNTW'(NUM_CLASSES - 1));
   assign completes = accept && bus.in_last && at_end;
   assign misframed = accept && (bus.in_last != at_end);
   assign ack       = bus.out_valid && bus.out_ack;
   // Negative values and Inf/NaN (all-ones exponent) are not valid exp outputs.
   assign elem_bad  = bus.in_data[datawidth-1] | (&bus.in_data[datawidth-2 -: 8]);

   // wbank and rbank only coincide when the shared bank cannot both complete and be acked.
   always_comb begin
      state_d[0] = state_q[0];
      state_d[1] = state_q[1];
      if (ack) begin
         state_d[rbank] = BANK_EMPTY;
      end
      if (completes) begin
         state_d[wbank] = BANK_FULL;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q[0] <= BANK_EMPTY;
         state_q[1] <= BANK_EMPTY;
      end else begin
         state_q[0] <= state_d[0];
         state_q[1] <= state_d[1];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wbank       <= 1'b0;
         rbank       <= 1'b0;
         idx         <= '0;
         bad         <= '0;
         frame_err_q <= 1'b0;
         vec_count_q <= '0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
               mem[b][i] <= '0;
            end
         end
      end else begin
         frame_err_q <= misframed;
         if (accept) begin
            mem[wbank][idx] <= bus.in_data;
            bad[wbank]      <= (idx == '0) ? elem_bad : (bad[wbank] | elem_bad);
            if (misframed) begin
               idx <= '0;
            end else if (completes) begin
               idx   <= '0;
               wbank <= ~wbank;
            end else begin
               idx <= idx + 1'b1;
            end
         end
         if (ack) begin
            rbank       <= ~rbank;
            vec_count_q <= vec_count_q + 8'd1;
         end
      end
   end

   always_comb begin
      flat = '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
         flat[i*datawidth +: datawidth] = mem[rbank][i];
      end
   end

   assign bus.softmax_flat = flat;
   assign bus.out_bad      = bus.out_valid && bad[rbank];
   assign bus.frame_err    = frame_err_q;
   assign bus.vec_count    = vec_count_q;
endmodule

// File: tb/tb_softmax_vector_collector.sv
// tb/tb_softmax_vector_collector.sv - directed and randomized checks of softmax_vector_collector against a queue model
module tb_softmax_vector_collector;
   localparam int DW = 32;
   localparam int NC = 10;
   localparam int FW = DW * NC;

   logic clock = 1'b0;
   logic reset = 1'b1;

   softmax_vector_collector_if #(.datawidth(DW), .NUM_CLASSES(NC)) bus ();

   softmax_vector_collector #(.datawidth(DW), .NUM_CLASSES(NC), .CNTW(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [FW-1:0] exp_q [$];
   logic [DW-1:0] cur_q [$];
   int            exp_vcount = 0;
   bit            exp_ferr   = 1'b0;

   logic [DW-1:0] tv1 [NC] = '{32'h402D70A4, 32'h3F800000, 32'h3F1B4396, 32'h3FD3089A,
                               32'h3F519653, 32'h3F519653, 32'h3FBEF34D, 32'h3EBC5048,
                               32'h4000E076, 32'h401D6A16};

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic bit vec_bad(input logic [FW-1:0] v);
      logic [DW-1:0] w;
      for (int i = 0; i < NC; i++) begin
         w = v[i*DW +: DW];
         if (w[31] || w[30:23] == 8'hFF) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic check_outputs();
      check("out_valid", bus.out_valid, exp_q.size() > 0);
      check("vec_count", bus.vec_count, exp_vcount[7:0]);
      check("frame_err", bus.frame_err, exp_ferr);
      if (exp_q.size() > 0) begin
         check("softmax_flat", bus.softmax_flat, exp_q[0]);
         check("out_bad", bus.out_bad, vec_bad(exp_q[0]));
      end
   endtask

   task automatic step(input bit v, input logic [DW-1:0] d, input bit l, input bit a, output bit acc);
      bit ready_m;
      bit ackd;
      logic [FW-1:0] packed_v;
      @(negedge clock);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_last  = l;
      bus.out_ack  = a;
      #1;
      ready_m = (exp_q.size() < 2);
      check("in_ready", bus.in_ready, ready_m);
      acc  = v && ready_m;
      ackd = a && (exp_q.size() > 0);
      @(posedge clock);
      #1;
      exp_ferr = 1'b0;
      if (ackd) begin
         void'(exp_q.pop_front());
         exp_vcount = (exp_vcount + 1) % 256;
      end
      if (acc) begin
         if (l != (cur_q.size() == NC - 1)) begin
            exp_ferr = 1'b1;
            cur_q.delete();
         end else begin
            cur_q.push_back(d);
            if (l) begin
               packed_v = '0;
               for (int i = 0; i < NC; i++) packed_v[i*DW +: DW] = cur_q[i];
               exp_q.push_back(packed_v);
               cur_q.delete();
            end
         end
      end
      check_outputs();
   endtask

   task automatic send(input logic [DW-1:0] d, input bit l, input bit a);
      bit acc;
      int n = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
         step(1'b1, d, l, a, acc);
         n++;
      end
      if (!acc) check("send_timeout", 1'b0, 1'b1);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_vec(input int bad_pos, input logic [DW-1:0] bad_word, input bit a);
      for (int i = 0; i < NC; i++) begin
         send((i == bad_pos) ? bad_word : (($urandom() & 32'h7FFF_FFFF) | 32'h0080_0000) & 32'h7F7F_FFFF,
              i == NC - 1, a);
      end
   endtask

   task automatic idle(input bit a);
      bit acc;
      step(1'b0, '0, 1'b0, a, acc);
   endtask

   bit acc0;

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      bus.out_ack  = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_bad", bus.out_bad, 1'b0);
      check("rst_frame_err", bus.frame_err, 1'b0);
      check("rst_vec_count", bus.vec_count, 8'd0);
      check("rst_flat", bus.softmax_flat, '0);

      for (int i = 0; i < NC; i++) send(tv1[i], i == NC - 1, 1'b0);
      check("t1_valid", bus.out_valid, 1'b1);
      check("t1_elem0", bus.softmax_flat[0 +: DW], 32'h402D70A4);
      check("t1_elem9", bus.softmax_flat[9*DW +: DW], 32'h401D6A16);
      check("t1_bad", bus.out_bad, 1'b0);
      idle(1'b1);
      idle(1'b0);

      send_vec(-1, '0, 1'b0);
      send_vec(-1, '0, 1'b0);
      check("t2_stall_ready", bus.in_ready, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, $urandom(), 1'b0, 1'b0, acc0);
      step(1'b1, 32'h3F00_0000, 1'b0, 1'b1, acc0);
      check("t2_vec_count", bus.vec_count, 8'd2);
      check("t2_ready_back", bus.in_ready, 1'b1);
      send(32'h3F00_0000, 1'b0, 1'b0);
      for (int i = 1; i < NC; i++) send(32'h3F00_0000 + i, i == NC - 1, 1'b0);
      repeat (3) idle(1'b1);

      for (int i = 0; i < 7; i++) send(32'h3E00_0000 + i, i == 6, 1'b0);
      check("t3_ferr", bus.frame_err, 1'b1);
      idle(1'b0);
      check("t3_no_valid", bus.out_valid, 1'b0);
      for (int i = 0; i < NC - 1; i++) send(32'h3D00_0000 + i, 1'b0, 1'b0);
      send(32'h3D00_0009, 1'b0, 1'b0);
      send_vec(-1, '0, 1'b0);
      idle(1'b1);

      send_vec(4, 32'hBF80_0000, 1'b0);
      check("t4_neg_bad", bus.out_bad, 1'b1);
      idle(1'b1);
      send_vec(4, 32'h7FC0_0000, 1'b0);
      check("t4_nan_bad", bus.out_bad, 1'b1);
      idle(1'b1);
      send_vec(-1, '0, 1'b0);
      check("t4_clean", bus.out_bad, 1'b0);
      idle(1'b1);

      send_vec(-1, '0, 1'b0);
      for (int i = 0; i < NC - 1; i++) send($urandom() & 32'h3FFF_FFFF, 1'b0, 1'b0);
      send(32'h3FAB_CDEF, 1'b1, 1'b1);
      check("t5_valid", bus.out_valid, 1'b1);
      check("t5_elem9", bus.softmax_flat[9*DW +: DW], 32'h3FAB_CDEF);
      idle(1'b1);

      for (int i = 0; i < 5; i++) send($urandom() & 32'h3FFF_FFFF, 1'b0, 1'b0);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("t6_valid", bus.out_valid, 1'b0);
      check("t6_vec_count", bus.vec_count, 8'd0);
      check("t6_flat", bus.softmax_flat, '0);
      check("t6_ready", bus.in_ready, 1'b1);
      exp_q.delete();
      cur_q.delete();
      exp_vcount = 0;
      exp_ferr   = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      repeat (3) idle(1'b0);
      for (int v = 0; v < 256; v++) send_vec(-1, '0, 1'b1);
      idle(1'b1);
      check("t6_wrap", bus.vec_count, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
